// File: rtl/tftp_tx_encode.sv
// ---------------------------------------------------------------------------
// tftp_tx_encode
// Builds one outgoing TFTP packet per start request and streams it byte by
// byte over a valid/ready interface.
//   DATA  : 00 03 blk_hi blk_lo + payload read from byte memory (0..512 bytes)
//   ERROR : 00 05 00 01 "File not found" 00 (19 bytes)
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  one-cycle build request (honoured in IDLE only)
//   pkt_type               0 = DATA, 1 = ERROR
//   block_num              TFTP block number (DATA only)
//   base_addr              file base address in memory
//   data_len               payload length, clamped to 512
//   mem_rd / mem_addr      memory read strobe and byte address
//   mem_data               memory read data, valid one cycle after mem_rd
//   tx_data/tx_valid/tx_ready/tx_last   outgoing byte stream
//   busy                   packet in progress
//   done                   one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module tftp_tx_encode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pkt_type,
    input  logic [15:0] block_num,
    input  logic [15:0] base_addr,
    input  logic [9:0]  data_len,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, HDR, PAY_RD, PAY_TX, ERR_MSG, FIN} state_t;

    state_t      state;
    logic        is_err;
    logic [15:0] blk;
    logic [15:0] page;     // base_addr + ((block_num-1) << 9), mod 2^16
    logic [9:0]  len;      // clamped payload length
    logic [9:0]  idx;      // payload byte index
    logic [3:0]  cnt;      // header / error-message byte index
    logic        cap;      // first PAY_TX cycle: mem_data is valid now

    logic xfer;
    assign xfer = tx_valid & tx_ready;

    function automatic logic [7:0] hdr_byte(input logic [1:0] i, input logic err,
                                            input logic [15:0] b);
        case (i)
            2'd0:    hdr_byte = 8'h00;
            2'd1:    hdr_byte = err ? 8'h05 : 8'h03;
            2'd2:    hdr_byte = err ? 8'h00 : b[15:8];
            default: hdr_byte = err ? 8'h01 : b[7:0];
        endcase
    endfunction

    // "File not found" followed by the 00 terminator.
    function automatic logic [7:0] err_char(input logic [3:0] i);
        case (i)
            4'd0:    err_char = 8'h46;
            4'd1:    err_char = 8'h69;
            4'd2:    err_char = 8'h6C;
            4'd3:    err_char = 8'h65;
            4'd4:    err_char = 8'h20;
            4'd5:    err_char = 8'h6E;
            4'd6:    err_char = 8'h6F;
            4'd7:    err_char = 8'h74;
            4'd8:    err_char = 8'h20;
            4'd9:    err_char = 8'h66;
            4'd10:   err_char = 8'h6F;
            4'd11:   err_char = 8'h75;
            4'd12:   err_char = 8'h6E;
            4'd13:   err_char = 8'h64;
            default: err_char = 8'h00;
        endcase
    endfunction

    // NOTE: all state uses non-blocking assignments so every register in this
    // block sees the pre-edge value of every other, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            is_err   <= 1'b0;
            blk      <= 16'd0;
            page     <= 16'd0;
            len      <= 10'd0;
            idx      <= 10'd0;
            cnt      <= 4'd0;
            cap      <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= 16'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;  // pulse; re-asserted only on the final handshake
            case (state)
                IDLE: begin
                    if (start) begin
                        is_err   <= pkt_type;
                        blk      <= block_num;
                        page     <= base_addr + ((block_num - 16'd1) << 9);
                        len      <= (data_len > 10'd512) ? 10'd512 : data_len;
                        idx      <= 10'd0;
                        cnt      <= 4'd0;
                        busy     <= 1'b1;
                        tx_data  <= 8'h00;
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (cnt == 4'd3) begin
                            cnt <= 4'd0;
                            if (is_err) begin
                                tx_data <= err_char(4'd0);
                                tx_last <= 1'b0;
                                state   <= ERR_MSG;
                            end else if (len == 10'd0) begin
                                tx_valid <= 1'b0;
                                tx_last  <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= FIN;
                            end else begin
                                tx_valid <= 1'b0;
                                mem_rd   <= 1'b1;
                                mem_addr <= page;
                                state    <= PAY_RD;
                            end
                        end else begin
                            cnt     <= cnt + 4'd1;
                            tx_data <= hdr_byte(cnt[1:0] + 2'd1, is_err, blk);
                            // Empty DATA packet ends on header byte 3.
                            tx_last <= !is_err && (len == 10'd0) && (cnt == 4'd2);
                        end
                    end
                end
                PAY_RD: begin
                    mem_rd <= 1'b0;
                    cap    <= 1'b1;
                    state  <= PAY_TX;
                end
                PAY_TX: begin
                    if (cap) begin
                        cap      <= 1'b0;
                        tx_data  <= mem_data;
                        tx_valid <= 1'b1;
                        tx_last  <= (idx == len - 10'd1);
                    end else if (xfer) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        if (idx == len - 10'd1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx      <= idx + 10'd1;
                            mem_rd   <= 1'b1;
                            mem_addr <= page + {6'd0, idx} + 16'd1;
                            state    <= PAY_RD;
                        end
                    end
                end
                ERR_MSG: begin
                    if (xfer) begin
                        if (cnt == 4'd14) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            cnt     <= cnt + 4'd1;
                            tx_data <= err_char(cnt + 4'd1);
                            tx_last <= (cnt == 4'd13);
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
